multi_sram_arb: RTL and testbench
=================================

MULTI_SRAM_ARB -- requirements
Module: multi_sram_arb

Interface
REQ-001 SHALL have parameter NUM_BANKS, default 4, number of independent single-port SRAM banks (power of 2, 2..16).
REQ-002 SHALL have parameter DATA_WIDTH, default 32, word width of every bank.
REQ-003 SHALL have parameter BANK_AW, default 8, per-bank word address width; bank depth = 2^BANK_AW.
REQ-004 SHALL have parameter RD_LATENCY, default 2, accept-to-response cycles for reads (legal 1..4).
REQ-005 SHALL derive localparam BSEL_W = log2(NUM_BANKS) and GAW = BSEL_W + BANK_AW (global address width).
REQ-006 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-007 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-008 SHALL have port req_valid  input  2  per-requester request valid (requester p = bit p).
REQ-009 SHALL have port req_ready  output  2  per-requester accept, combinational from this cycle's valids/addresses/arbiter state.
REQ-010 SHALL have port req_we  input  2  1 = write, 0 = read.
REQ-011 SHALL have port req_addr  input  2*GAW  packed; slice p = [p*GAW +: GAW]; bank = upper BSEL_W bits, word = lower BANK_AW bits.
REQ-012 SHALL have port req_wdata  input  2*DATA_WIDTH  packed write data, slice p as above.
REQ-013 SHALL have port rsp_valid  output  2  per-requester read-data valid, one-cycle pulse per read.
REQ-014 SHALL have port rsp_rdata  output  2*DATA_WIDTH  packed read data, valid when rsp_valid[p].
REQ-015 SHALL have port conflict_cnt  output  16  saturating count of cycles where a request was refused.

Function
REQ-016 A request p SHALL be accepted on a rising edge where req_valid[p] and req_ready[p] are both 1.
REQ-017 When the two valid requests target different banks, or only one is valid, req_ready SHALL be 1 for every valid requester.
REQ-018 When both valid requests target the same bank, exactly one SHALL be granted: the requester indicated by that bank's round-robin pointer.
REQ-019 Each bank SHALL hold a 1-bit pointer; after a conflict cycle it SHALL toggle to the loser; non-conflict cycles SHALL leave it unchanged.
REQ-020 req_ready[p] SHALL be 0 when req_valid[p] is 0.
REQ-021 An accepted write SHALL update the addressed word at that edge; writes SHALL produce no response.
REQ-022 An accepted read SHALL assert rsp_valid[p] exactly RD_LATENCY cycles after the accepting edge, with rsp_rdata[p] equal to the word contents at the accepting edge.
REQ-023 A read accepted one cycle after a write to the same address SHALL return the new data.
REQ-024 Back-to-back reads from one requester SHALL be accepted every cycle; responses SHALL be in order, one per cycle, with no bubbles beyond the request pattern.
REQ-025 Read latency SHALL be realised by a per-requester valid/data shift pipeline of RD_LATENCY stages; responses have no backpressure.
REQ-026 rsp_rdata[p] SHALL hold its last value when rsp_valid[p] is 0.
REQ-027 conflict_cnt SHALL increment by 1 on every edge where a same-bank conflict refuses one requester; it SHALL saturate at 16'hFFFF.
REQ-028 A refused request SHALL be re-arbitrated the next cycle with no state lost; the requester keeps inputs stable.

Reset
REQ-029 While rst = 0: rsp_valid = 0, rsp_rdata = 0, conflict_cnt = 0, all bank pointers = requester 0, pipelines cleared.
REQ-030 Reset asserted mid-operation SHALL discard in-flight reads (no rsp_valid after release for requests accepted before reset).
REQ-031 Bank memory contents SHALL NOT be reset.
REQ-032 req_ready SHALL be 0 while rst = 0.

Verification
REQ-033 Write 32'hA5A5_0001 to addr 0x005 via p0, next cycle read 0x005 via p1 -> rsp_valid[1] exactly 2 cycles after accept, rsp_rdata[1] = 32'hA5A5_0001.
REQ-034 p0 reads bank 0, p1 reads bank 2 same cycle -> req_ready = 2'b11, both responses same cycle, conflict_cnt unchanged.
REQ-035 Both ports hold reads to bank 1 for 4 cycles -> grants alternate p0,p1,p0,p1; conflict_cnt = 4.
REQ-036 p0 streams reads to 0x000..0x007 every cycle -> 8 consecutive rsp_valid[0] pulses, data in address order.
REQ-037 Read accepted, rst driven low 1 cycle later, released -> no rsp_valid pulse, conflict_cnt = 0, earlier-written data still readable.
REQ-038 Force 65540 conflict cycles -> conflict_cnt = 16'hFFFF and holds.

Source files
------------

// File: rtl/multi_sram_arb.sv
// rtl/multi_sram_arb.sv - two-requester arbiter over NUM_BANKS single-port SRAM banks
module multi_sram_arb #(
    parameter int NUM_BANKS  = 4,
    parameter int DATA_WIDTH = 32,
    parameter int BANK_AW    = 8,
    parameter int RD_LATENCY = 2,
    localparam int BSEL_W    = $clog2(NUM_BANKS),
    localparam int GAW       = BSEL_W + BANK_AW
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [1:0]              req_valid,
    output logic [1:0]              req_ready,
    input  logic [1:0]              req_we,
    input  logic [2*GAW-1:0]        req_addr,
    input  logic [2*DATA_WIDTH-1:0] req_wdata,
    output logic [1:0]              rsp_valid,
    output logic [2*DATA_WIDTH-1:0] rsp_rdata,
    output logic [15:0]             conflict_cnt
);
    localparam int DEPTH = 1 << BANK_AW;

    logic [DATA_WIDTH-1:0] mem [NUM_BANKS][DEPTH];

    logic [BSEL_W-1:0]     bsel    [2];
    logic [BANK_AW-1:0]    word    [2];
    logic [DATA_WIDTH-1:0] wdata   [2];
    logic [DATA_WIDTH-1:0] rd_word [2];

    logic [NUM_BANKS-1:0]  rr_ptr;
    logic                  conflict;
    logic [1:0]            accept;
    logic [1:0]            rd_acc;
    logic [1:0]            wr_acc;

    logic [NUM_BANKS-1:0]  bank_we;
    logic [BANK_AW-1:0]    bank_word [NUM_BANKS];
    logic [DATA_WIDTH-1:0] bank_din  [NUM_BANKS];

    for (genvar p = 0; p < 2; p++) begin : g_split
        assign bsel[p]    = req_addr[p*GAW+BANK_AW +: BSEL_W];
        assign word[p]    = req_addr[p*GAW +: BANK_AW];
        assign wdata[p]   = req_wdata[p*DATA_WIDTH +: DATA_WIDTH];
        assign rd_word[p] = mem[bsel[p]][word[p]];
    end

    assign conflict = (req_valid == 2'b11) && (bsel[0] == bsel[1]);

    // On a same-bank collision the bank's pointer names the winner.
    always_comb begin
        req_ready = 2'b00;
        if (rst) begin
            req_ready = req_valid;
            if (conflict) begin
                req_ready = rr_ptr[bsel[0]] ? 2'b10 : 2'b01;
            end
        end
    end

    assign accept = req_valid & req_ready;
    assign rd_acc = accept & ~req_we;
    assign wr_acc = accept & req_we;

    // Arbitration guarantees at most one writer per bank, so each bank has one port.
    always_comb begin
        for (int b = 0; b < NUM_BANKS; b++) begin
            bank_we[b]   = 1'b0;
            bank_word[b] = word[0];
            bank_din[b]  = wdata[0];
            if (wr_acc[0] && (bsel[0] == BSEL_W'(b))) begin
                bank_we[b] = 1'b1;
            end else if (wr_acc[1] && (bsel[1] == BSEL_W'(b))) begin
                bank_we[b]   = 1'b1;
                bank_word[b] = word[1];
                bank_din[b]  = wdata[1];
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int b = 0; b < NUM_BANKS; b++) begin
            if (bank_we[b]) begin
                mem[b][bank_word[b]] <= bank_din[b];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_ptr       <= '0;
            conflict_cnt <= '0;
        end else if (conflict) begin
            rr_ptr[bsel[0]] <= ~rr_ptr[bsel[0]];
            if (conflict_cnt != 16'hFFFF) begin
                conflict_cnt <= conflict_cnt + 16'd1;
            end
        end
    end

    // Data stages only advance behind a valid so the output word holds between pulses.
    for (genvar p = 0; p < 2; p++) begin : g_pipe
        logic [RD_LATENCY-1:0] pv;
        logic [DATA_WIDTH-1:0] pd [RD_LATENCY];

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                pv <= '0;
                for (int i = 0; i < RD_LATENCY; i++) begin
                    pd[i] <= '0;
                end
            end else begin
                pv[0] <= rd_acc[p];
                if (rd_acc[p]) begin
                    pd[0] <= rd_word[p];
                end
                for (int i = 1; i < RD_LATENCY; i++) begin
                    pv[i] <= pv[i-1];
                    if (pv[i-1]) begin
                        pd[i] <= pd[i-1];
                    end
                end
            end
        end

        assign rsp_valid[p]                           = pv[RD_LATENCY-1];
        assign rsp_rdata[p*DATA_WIDTH +: DATA_WIDTH] = pd[RD_LATENCY-1];
    end
endmodule

// File: tb/tb_multi_sram_arb.sv
// tb/tb_multi_sram_arb.sv - table-driven and scoreboard bench for multi_sram_arb
module tb_multi_sram_arb;
    localparam int L   = 2;
    localparam int GAW = 10;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req_valid, req_ready, req_we, rsp_valid;
    logic [19:0] req_addr;
    logic [63:0] req_wdata, rsp_rdata;
    logic [15:0] conflict_cnt;

    multi_sram_arb #(.NUM_BANKS(4), .DATA_WIDTH(32), .BANK_AW(8), .RD_LATENCY(L)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .conflict_cnt(conflict_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  valid;
        logic [1:0]  we;
        logic [9:0]  a0;
        logic [9:0]  a1;
        logic [31:0] d0;
        logic [31:0] d1;
        logic [1:0]  exp_ready;
    } vec_t;

    typedef struct {
        int          due;
        logic [31:0] data;
    } exp_t;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          exp_conflict = 0;
    int          rsp_cnt [2] = '{0, 0};
    logic [31:0] last_data [2] = '{32'h0, 32'h0};
    logic [31:0] model_mem [0:1023];
    exp_t        sbq [2][$];
    vec_t        vecs [9];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp_v);
        end
    endtask

    task automatic drive(input logic [1:0] v, input logic [1:0] we,
                         input logic [9:0] a0, input logic [9:0] a1,
                         input logic [31:0] d0, input logic [31:0] d1,
                         input logic [1:0] er, input string nm);
        logic [9:0]  a [2];
        logic [31:0] d [2];
        int          edge_no;
        a[0] = a0; a[1] = a1; d[0] = d0; d[1] = d1;
        req_valid = v;
        req_we    = we;
        req_addr  = {a1, a0};
        req_wdata = {d1, d0};
        #1;
        chk({nm, "_ready"}, {30'd0, req_ready}, {30'd0, er});
        edge_no = cyc + 1;
        for (int p = 0; p < 2; p++)
            if (v[p] && er[p] && !we[p]) sbq[p].push_back('{edge_no + L, model_mem[a[p]]});
        for (int p = 0; p < 2; p++)
            if (v[p] && er[p] && we[p]) model_mem[a[p]] = d[p];
        if (v == 2'b11 && er != 2'b11 && exp_conflict < 65535) exp_conflict++;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(2'b00, 2'b00, 10'h0, 10'h0, 32'h0, 32'h0, 2'b00, "idle");
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst !== 1'b1) begin
            chk("reset_rsp_valid", {30'd0, rsp_valid}, 32'd0);
            chk("reset_rsp_rdata0", rsp_rdata[31:0], 32'd0);
            chk("reset_rsp_rdata1", rsp_rdata[63:32], 32'd0);
        end else begin
            for (int p = 0; p < 2; p++) begin
                while (sbq[p].size() > 0 && sbq[p][0].due < cyc + 1) begin
                    checks++;
                    errors++;
                    $display("FAIL rsp_missing p%0d: got no pulse, expected one due at edge %0d", p, sbq[p][0].due);
                    void'(sbq[p].pop_front());
                end
                if (rsp_valid[p]) begin
                    rsp_cnt[p]++;
                    if (sbq[p].size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL rsp_unexpected p%0d: got pulse at edge %0d, expected none", p, cyc + 1);
                    end else begin
                        e = sbq[p].pop_front();
                        chk($sformatf("rsp_due_p%0d", p), cyc + 1, e.due);
                        chk($sformatf("rsp_data_p%0d", p), rsp_rdata[p*32 +: 32], e.data);
                        last_data[p] = e.data;
                    end
                end else begin
                    chk($sformatf("rsp_hold_p%0d", p), rsp_rdata[p*32 +: 32], last_data[p]);
                end
            end
        end
    end

    initial begin
        int base;
        vecs[0] = '{2'b01, 2'b01, 10'h005, 10'h000, 32'hA5A5_0001, 32'h0, 2'b01};
        vecs[1] = '{2'b10, 2'b00, 10'h000, 10'h005, 32'h0, 32'h0, 2'b10};
        vecs[2] = '{2'b11, 2'b11, 10'h003, 10'h203, 32'h1111_1111, 32'h2222_2222, 2'b11};
        vecs[3] = '{2'b11, 2'b00, 10'h003, 10'h203, 32'h0, 32'h0, 2'b11};
        vecs[4] = '{2'b11, 2'b10, 10'h005, 10'h105, 32'h0, 32'h3333_3333, 2'b11};
        vecs[5] = '{2'b00, 2'b11, 10'h105, 10'h105, 32'h0, 32'h0, 2'b00};
        vecs[6] = '{2'b11, 2'b11, 10'h110, 10'h111, 32'h4444_4444, 32'h5555_5555, 2'b01};
        vecs[7] = '{2'b10, 2'b10, 10'h000, 10'h111, 32'h0, 32'h5555_5555, 2'b10};
        vecs[8] = '{2'b11, 2'b00, 10'h110, 10'h111, 32'h0, 32'h0, 2'b10};

        rst = 1'b0;
        req_valid = 2'b11; req_we = 2'b00; req_addr = '0; req_wdata = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("ready_in_reset", {30'd0, req_ready}, 32'd0);
        chk("cnt_in_reset", {16'd0, conflict_cnt}, 32'd0);
        req_valid = 2'b00;
        rst = 1'b1;

        for (int i = 0; i < 9; i++)
            drive(vecs[i].valid, vecs[i].we, vecs[i].a0, vecs[i].a1,
                  vecs[i].d0, vecs[i].d1, vecs[i].exp_ready, $sformatf("vec%0d", i));
        idle(3);
        chk("cnt_after_table", {16'd0, conflict_cnt}, exp_conflict);

        for (int i = 0; i < 4; i++)
            drive(2'b11, 2'b00, 10'h105, 10'h111, 32'h0, 32'h0, (i % 2 == 0) ? 2'b01 : 2'b10,
                  $sformatf("alt%0d", i));
        idle(3);
        chk("cnt_after_alt", {16'd0, conflict_cnt}, exp_conflict);

        for (int i = 0; i < 8; i++)
            drive(2'b01, 2'b01, 10'(i), 10'h0, 32'hC0DE_0000 + i, 32'h0, 2'b01, "stream_wr");
        base = rsp_cnt[0];
        for (int i = 0; i < 8; i++)
            drive(2'b01, 2'b00, 10'(i), 10'h0, 32'h0, 32'h0, 2'b01, "stream_rd");
        idle(4);
        chk("stream_pulses", rsp_cnt[0] - base, 32'd8);

        drive(2'b01, 2'b00, 10'h005, 10'h0, 32'h0, 32'h0, 2'b01, "pre_reset_rd");
        req_valid = 2'b00;
        @(posedge clk);
        #1;
        rst = 1'b0;
        sbq[0].delete();
        sbq[1].delete();
        last_data[0] = 32'h0;
        last_data[1] = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        chk("cnt_cleared", {16'd0, conflict_cnt}, 32'd0);
        rst = 1'b1;
        exp_conflict = 0;
        idle(3);
        drive(2'b10, 2'b00, 10'h0, 10'h005, 32'h0, 32'h0, 2'b10, "post_reset_rd");
        idle(4);

        model_mem[10'h3F0] = 32'hDEAD_0000;
        req_valid = 2'b11; req_we = 2'b11;
        req_addr  = {10'h3F0, 10'h3F0};
        req_wdata = {32'hDEAD_0000, 32'hDEAD_0000};
        repeat (65540) @(posedge clk);
        #1;
        chk("cnt_saturated", {16'd0, conflict_cnt}, 32'h0000_FFFF);
        repeat (3) @(posedge clk);
        #1;
        chk("cnt_holds", {16'd0, conflict_cnt}, 32'h0000_FFFF);
        req_valid = 2'b00;
        drive(2'b01, 2'b00, 10'h3F0, 10'h0, 32'h0, 32'h0, 2'b01, "sat_rd");
        idle(4);

        chk("sbq0_drained", sbq[0].size(), 32'd0);
        chk("sbq1_drained", sbq[1].size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
